// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: byte FIFO fed by core stores, drained by an 8N1 serializer.
// Register window: TXDATA at 0x0 (write-only), STATUS at 0x4 (read; any write clears overflow).
module uart_tx_mmio #(
    parameter int CLK_HZ = 12000000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [31:0] address,
    input  logic        sel,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        tx
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST  = CNT_W'(DIV - 1);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_next;
    logic [2:0]       bit_cnt, bit_cnt_next;
    logic [7:0]       shift_reg, shift_next;
    logic [7:0]       fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             overflow;
    logic             full, empty, pop, push_req, push, status_wr, baud_tick;
    logic             unused_bits;

    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign baud_tick = (baud_cnt == BAUD_LAST);
    assign push_req  = sel && mem_write && (address[3:2] == 2'b00);
    assign status_wr = sel && mem_write && (address[3:2] == 2'b01);
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still taken.
    assign push      = push_req && (!full || pop);

    assign unused_bits = ^{mem_read, address[31:4], address[1:0], write_data[31:8]};

    always_comb begin
        state_next    = state;
        baud_cnt_next = baud_cnt + 1'b1;
        bit_cnt_next  = bit_cnt;
        shift_next    = shift_reg;
        pop           = 1'b0;
        case (state)
            IDLE: begin
                baud_cnt_next = '0;
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_mem[rd_ptr];
                    state_next = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    baud_cnt_next = '0;
                    bit_cnt_next  = '0;
                    state_next    = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    baud_cnt_next = '0;
                    shift_next    = {1'b1, shift_reg[7:1]};
                    bit_cnt_next  = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    baud_cnt_next = '0;
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '1;
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_cnt_next;
            bit_cnt   <= bit_cnt_next;
            shift_reg <= shift_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (status_wr) begin
                overflow <= 1'b0;
            end else if (push_req && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push) begin
            fifo_mem[wr_ptr] <= write_data[7:0];
        end
    end

    always_comb begin
        read_data = '0;
        if (sel && (address[3:2] == 2'b01)) begin
            read_data[0]   = (state != IDLE);
            read_data[1]   = full;
            read_data[2]   = empty;
            read_data[3]   = overflow;
            read_data[8:4] = 5'(count);
        end
    end

    always_comb begin
        tx = 1'b1;
        case (state)
            START:   tx = 1'b0;
            DATA:    tx = shift_reg[0];
            default: tx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Scoreboard bench for uart_tx_mmio: accepted TXDATA bytes are queued, a serial
// receiver on tx pops and compares them; STATUS and timing are checked directly.
module tb_uart_tx_mmio;

    localparam int CLK_HZ = 12000000;
    localparam int BAUD   = 115200;
    localparam int DEPTH  = 4;
    localparam int DIV    = CLK_HZ / BAUD;
    localparam int FRAME  = 10 * DIV;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] address;
    logic        sel;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        tx;

    uart_tx_mmio #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .address    (address),
        .sel        (sel),
        .write_data (write_data),
        .read_data  (read_data),
        .tx         (tx)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int         compared   = 0;
    int         mismatched = 0;
    logic [7:0] sb[$];
    int         start_q[$];
    int         frames_rx  = 0;
    int         last_start = 0;
    bit         frame_abort;
    logic [7:0] rx_byte;
    logic       start_bit, stop_bit;
    logic [31:0] rd_val;
    int         base, lows;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic waitBit(input int n);
        repeat (n) begin
            @(negedge clk);
            if (!reset) frame_abort = 1'b1;
        end
    endtask

    // Serial receiver: samples each bit at its midpoint, counted from the first low sample.
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && tx === 1'b0) begin
                start_q.push_back(cycle);
                last_start  = cycle;
                frame_abort = 1'b0;
                waitBit(DIV / 2);
                start_bit = tx;
                for (int i = 0; i < 8; i++) begin
                    waitBit(DIV);
                    rx_byte[i] = tx;
                end
                waitBit(DIV);
                stop_bit = tx;
                if (!frame_abort) begin
                    checkOutput("start_bit", {31'h0, start_bit}, 32'h0);
                    checkOutput("stop_bit", {31'h0, stop_bit}, 32'h1);
                    if (sb.size() == 0)
                        checkOutput("unexpected_frame", {24'h0, rx_byte}, 32'h100);
                    else
                        checkOutput("frame_data", {24'h0, rx_byte}, {24'h0, sb.pop_front()});
                    frames_rx++;
                end
            end
        end
    end

    task automatic applyStimulus(input logic wr, input logic s, input logic [1:0] off,
                                 input logic [31:0] data);
        mem_write  = wr;
        sel        = s;
        address    = {28'h0, off, 2'b00};
        write_data = data;
        @(posedge clk);
        #1;
        mem_write  = 1'b0;
        sel        = 1'b0;
        address    = '0;
        write_data = '0;
    endtask

    task automatic writeTx(input logic [7:0] d, input bit accepted);
        applyStimulus(1'b1, 1'b1, 2'b00, {24'hC0FFEE, d});
        if (accepted) sb.push_back(d);
    endtask

    task automatic readReg(input logic [1:0] off, input logic s, output logic [31:0] v);
        sel      = s;
        address  = {28'h0, off, 2'b00};
        mem_read = 1'b1;
        @(negedge clk);
        v = read_data;
        @(posedge clk);
        #1;
        sel      = 1'b0;
        mem_read = 1'b0;
        address  = '0;
    endtask

    task automatic checkStatus(input string tag, input logic [31:0] exp);
        logic [31:0] v;
        readReg(2'b01, 1'b1, v);
        checkOutput(tag, v, exp);
    endtask

    task automatic waitUntil(input int c);
        while (cycle < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitFrames(input int n, input int budget);
        int left = budget;
        while (frames_rx < n && left > 0) begin
            @(posedge clk);
            #1;
            left--;
        end
        checkOutput("frames_done", frames_rx, n);
    endtask

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset      = 1'b0;
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        sel        = 1'b0;
        address    = '0;
        write_data = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("reset_tx", {31'h0, tx}, 32'h1);
        @(posedge clk);
        #1;
        checkStatus("reset_status", 32'h004);

        // Single byte: start bit one edge after the accepting edge, exact frame length.
        writeTx(8'h55, 1'b1);
        @(negedge clk);
        checkOutput("latency_idle", {31'h0, tx}, 32'h1);
        @(negedge clk);
        checkOutput("latency_start", {31'h0, tx}, 32'h0);
        @(posedge clk);
        #1;
        checkStatus("busy_status", 32'h005);
        waitFrames(1, 2 * FRAME);
        waitUntil(last_start + FRAME - 1);
        checkStatus("stop_tail_busy", 32'h005);
        waitUntil(last_start + FRAME);
        checkStatus("single_done", 32'h004);

        // Back-to-back frames separated by a single idle cycle.
        base = frames_rx;
        start_q.delete();
        writeTx(8'hA5, 1'b1);
        writeTx(8'h3C, 1'b1);
        writeTx(8'hFF, 1'b1);
        waitFrames(base + 3, 4 * FRAME);
        checkOutput("gap_1_2", start_q[1] - start_q[0], FRAME + 1);
        checkOutput("gap_2_3", start_q[2] - start_q[1], FRAME + 1);
        waitUntil(last_start + FRAME);
        checkStatus("b2b_done", 32'h004);

        // Overflow: sixth write is dropped, then a STATUS write clears only overflow.
        base = frames_rx;
        writeTx(8'h11, 1'b1);
        writeTx(8'h22, 1'b1);
        writeTx(8'h33, 1'b1);
        writeTx(8'h44, 1'b1);
        writeTx(8'h55, 1'b1);
        writeTx(8'h66, 1'b0);
        checkStatus("ovf_status", 32'h04B);
        applyStimulus(1'b1, 1'b1, 2'b01, 32'h0);
        checkStatus("ovf_cleared", 32'h043);

        // Full FIFO, write lands on the pop edge right after STOP.
        waitUntil(last_start + FRAME);
        writeTx(8'h12, 1'b1);
        checkStatus("full_pop_status", 32'h043);
        waitFrames(base + 6, 7 * FRAME);
        waitUntil(last_start + FRAME);
        checkStatus("ovf_done", 32'h004);

        // Decode: deselected and unmapped writes are ignored, deselected reads are zero.
        applyStimulus(1'b1, 1'b0, 2'b00, 32'h77);
        applyStimulus(1'b1, 1'b1, 2'b10, 32'h78);
        applyStimulus(1'b1, 1'b1, 2'b11, 32'h79);
        checkStatus("decode_status", 32'h004);
        readReg(2'b01, 1'b0, rd_val);
        checkOutput("read_sel0", rd_val, 32'h0);
        readReg(2'b00, 1'b1, rd_val);
        checkOutput("read_txdata", rd_val, 32'h0);
        readReg(2'b10, 1'b1, rd_val);
        checkOutput("read_off8", rd_val, 32'h0);

        // Reset pulse in the middle of data bit 3 (a zero bit of 0xF0).
        writeTx(8'hF0, 1'b1);
        writeTx(8'h0F, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        waitUntil(last_start + 4 * DIV + DIV / 2);
        checkOutput("pre_reset_tx", {31'h0, tx}, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("reset_abort_tx", {31'h0, tx}, 32'h1);
        sb.delete();
        @(posedge clk);
        #1;
        checkStatus("reset_abort_status", 32'h004);
        lows = 0;
        repeat (2 * FRAME) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        checkOutput("no_frames_after_reset", lows, 0);

        checkOutput("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
